// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: one-outstanding-request fetcher feeding a small prefetch queue toward the core.
// Latency: a redirect reaches instr_valid in 2 cycles with zero-wait memory; one instruction per cycle sustained.
// Backpressure: stops issuing requests while the queue would be full; FETCH_STATS_EN adds fetch/stall counters.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready,
    output logic [31:0] fetch_count,
    output logic [31:0] stall_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_DISCARD = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic              req_q, req_d;
    logic [31:0]       addr_q, addr_d;
    logic [31:0]       fetch_pc_q, fetch_pc_d;
    logic [31:0]       target_q, target_d;

    logic [31:0]       mem_instr_q [FIFO_DEPTH];
    logic [31:0]       mem_pc_q    [FIFO_DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, wr_ptr_q;
    logic [CNT_W-1:0]  count_q, count_d;

    logic [31:0]       redirect_pc_al;
    logic              push, pop;

    // The low address bits of a redirect target are ignored.
    assign redirect_pc_al = redirect_pc & ~32'h0000_0003;

    assign instr_valid = (count_q != '0);
    assign instr       = mem_instr_q[rd_ptr_q];
    assign instr_pc    = mem_pc_q[rd_ptr_q];
    assign imem_req    = req_q;
    assign imem_addr   = addr_q;

    // Queue control: a redirect flushes and overrides both push and pop.
    always_comb begin
        pop     = instr_valid & instr_ready & ~redirect;
        push    = (state_q == ST_WAIT) & imem_ack & ~redirect;
        count_d = count_q;
        if (redirect) begin
            count_d = '0;
        end else begin
            if (push) count_d = count_d + CNT_ONE;
            if (pop)  count_d = count_d - CNT_ONE;
        end
    end

    // Fetch FSM: decides the next request from the resulting queue occupancy.
    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        addr_d     = addr_q;
        fetch_pc_d = fetch_pc_q;
        target_d   = target_q;
        case (state_q)
            ST_IDLE: begin
                if (redirect) begin
                    req_d   = 1'b1;
                    addr_d  = redirect_pc_al;
                    state_d = ST_WAIT;
                end else if (count_d < DEPTH_C) begin
                    req_d   = 1'b1;
                    addr_d  = fetch_pc_q;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (imem_ack) begin
                    if (redirect) begin
                        req_d  = 1'b1;
                        addr_d = redirect_pc_al;
                    end else begin
                        fetch_pc_d = addr_q + 32'd4;
                        if (count_d < DEPTH_C) begin
                            req_d  = 1'b1;
                            addr_d = addr_q + 32'd4;
                        end else begin
                            req_d   = 1'b0;
                            state_d = ST_IDLE;
                        end
                    end
                end else if (redirect) begin
                    target_d = redirect_pc_al;
                    state_d  = ST_DISCARD;
                end
            end
            ST_DISCARD: begin
                if (imem_ack) begin
                    req_d   = 1'b1;
                    addr_d  = redirect ? redirect_pc_al : target_q;
                    state_d = ST_WAIT;
                end else if (redirect) begin
                    target_d = redirect_pc_al;
                end
            end
            default: begin
                req_d   = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control state registers; reset aborts any outstanding request.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            req_q      <= 1'b0;
            addr_q     <= RESET_PC;
            fetch_pc_q <= RESET_PC;
            target_q   <= RESET_PC;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            addr_q     <= addr_d;
            fetch_pc_q <= fetch_pc_d;
            target_q   <= target_d;
            count_q    <= count_d;
            if (redirect) begin
                rd_ptr_q <= '0;
                wr_ptr_q <= '0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
                if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
        end
    end

    // Queue storage: data needs no reset since count_q gates visibility.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_instr_q[wr_ptr_q] <= imem_rdata;
            mem_pc_q[wr_ptr_q]    <= addr_q;
        end
    end

`ifdef FETCH_STATS_EN
    logic [31:0] fetch_cnt_q, stall_cnt_q;

    // Delivered-instruction and starved-cycle counters, wrapping at 2^32.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (pop)                        fetch_cnt_q <= fetch_cnt_q + 32'd1;
            if (instr_ready && !instr_valid) stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign fetch_count = fetch_cnt_q;
    assign stall_count = stall_cnt_q;
`else
    assign fetch_count = 32'd0;
    assign stall_count = 32'd0;
`endif

endmodule
